uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Round-robin arbiter and sequencer that shares one UART transmitter between two byte requesters.
- Accepts a byte from one requester via valid/ready handshake.
- Launches it on the shared transmitter with a one-cycle start strobe, then tracks the transmitter's busy flag until the frame completes.
- Sits between the system-clock-domain byte sources and the UART TX datapath, on the clk_sis side.

Parameters:
DATA_W, 8, width of transmitted byte
ACK_TIMEOUT, 16, clk_sis cycles to wait for tx_busy to rise after tx_start before aborting
CNT_W, 16, width of per-requester frame counters (used only with UART_ARB_STATS_EN)

Ports:
clk_sis  input  1  system clock; the block's only clock, all logic on rising edge
rst  input  1  synchronous reset, active-low; sampled on rising clk_sis
req0_valid  input  1  requester 0 has a byte
req0_data  input  DATA_W  requester 0 byte
req0_ready  output  1  requester 0 byte accepted this cycle (when valid also high)
req1_valid  input  1  requester 1 has a byte
req1_data  input  DATA_W  requester 1 byte
req1_ready  output  1  requester 1 byte accepted this cycle
tx_start  output  1  one-cycle launch strobe to transmitter
tx_data  output  DATA_W  byte to transmit, held stable for the whole frame
tx_busy  input  1  transmitter busy (high from frame start through stop bit)
grant  output  2  one-hot owner of transmitter; 00 when idle
busy  output  1  high whenever state is not IDLE
ack_err  output  1  one-cycle pulse: transmitter failed to go busy within ACK_TIMEOUT
err_id  output  1  requester index of last ack_err; holds until next error
tx_count0  output  CNT_W  frames completed for requester 0 (UART_ARB_STATS_EN only)
tx_count1  output  CNT_W  frames completed for requester 1 (UART_ARB_STATS_EN only)

Behaviour:
- Reset (rst==0 at rising edge):
  - state=IDLE; tx_start=0, tx_data=0, grant=00, busy=0, ack_err=0, err_id=0, counters=0.
  - Last-served pointer=1, so requester 0 wins the first tie.
  - Reset mid-frame abandons the frame; tx_start/grant are low from the next edge.
- States: IDLE, LAUNCH, WAIT_ACK, WAIT_DONE.
- IDLE:
  - Winner = the only valid requester; if both are valid, the one not equal to the last-served pointer.
  - reqN_ready is combinational: (state==IDLE) && winner==N && reqN_valid. Never high for both requesters, never high outside IDLE.
  - On handshake: tx_data<=reqN_data, grant<=onehot(N), pointer<=N, go LAUNCH.
- LAUNCH: tx_start=1 for exactly this cycle (registered, one cycle after accept); clear timeout counter; go WAIT_ACK.
- WAIT_ACK:
  - tx_busy==1 -> WAIT_DONE.
  - Else increment timer. When timer reaches ACK_TIMEOUT with no busy: ack_err=1 for one cycle, err_id<=granted index, grant<=00, go IDLE. Byte dropped, no count.
- WAIT_DONE: on tx_busy==0 -> IDLE, grant<=00, increment the granted requester's counter.
- Latency:
  - Accept at cycle N -> tx_start at N+1.
  - tx_busy seen low at cycle M -> IDLE at M+1; next accept possible at M+1.
- tx_data changes only on accept, so it is stable from LAUNCH through the frame end.
- A requester dropping valid before the handshake has no effect. Data is captured only on the handshake cycle.
- Both valid every cycle: grants strictly alternate 0,1,0,1.
- Counters wrap from 2^CNT_W-1 to 0.

Optional Feature:
UART_ARB_STATS_EN
- Defined: tx_count0/tx_count1 ports and counters exist, behaving as above.
- Undefined: ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset: hold rst=0 for 3 cycles with both valid -> all outputs 0, both ready=0; release -> req0 accepted first cycle.
- Single byte: req0 sends 0xA5; transmitter model raises busy 2 cycles after tx_start and holds it for 10 cycles.
  - Required: tx_start one cycle after accept, tx_data=0xA5 throughout, grant=01, return to IDLE one cycle after busy falls, tx_count0=1.
- Contention: both valid continuously with req0=0x11, req1=0x22 -> transmitted sequence 0x11,0x22,0x11,0x22; never two readies in one cycle.
- Timeout: ACK_TIMEOUT=16, tx_busy tied 0, req1 sends 0x3C.
  - Required: ack_err pulse exactly 16 cycles after leaving LAUNCH, err_id=1, grant=00, tx_count1 unchanged, next request accepted.
- Reset mid-frame: assert rst=0 during WAIT_DONE -> next edge state IDLE, grant=00, counters 0, no spurious tx_start.
- Wrap (STATS_EN, CNT_W=4): 17 frames from req0 -> tx_count0=1.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
//------------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter between two byte requesters. A round-robin
// arbiter accepts a byte over a valid/ready handshake. The sequencer then
// launches it with a one-cycle start strobe and follows the transmitter's
// busy flag until the frame is complete. If the transmitter never acknowledges
// the launch, the byte is dropped and an error pulse is raised.
//
// Optional feature macro: UART_ARB_STATS_EN
//   When defined, the per-requester frame counters tx_count0/tx_count1 and
//   their ports exist. When undefined, they are absent. All other behaviour
//   is identical in both builds.
//
// Parameters:
//   DATA_W       width of the transmitted byte
//   ACK_TIMEOUT  clk_sis cycles to wait for tx_busy after tx_start
//   CNT_W        width of the frame counters (statistics build only)
//
// Ports:
//   clk_sis      system clock; all logic is on its rising edge
//   rst          synchronous reset, active low
//   req0_valid   requester 0 has a byte
//   req0_data    requester 0 byte
//   req0_ready   requester 0 byte accepted this cycle (combinational)
//   req1_valid   requester 1 has a byte
//   req1_data    requester 1 byte
//   req1_ready   requester 1 byte accepted this cycle (combinational)
//   tx_start     one-cycle launch strobe to the transmitter
//   tx_data      byte being transmitted, stable for the whole frame
//   tx_busy      transmitter busy, from frame start through the stop bit
//   grant        one-hot owner of the transmitter; 00 when idle
//   busy         high whenever the sequencer is not idle
//   ack_err      one-cycle pulse: the transmitter never went busy
//   err_id       requester index of the last ack_err
//   tx_count0    frames completed for requester 0 (UART_ARB_STATS_EN)
//   tx_count1    frames completed for requester 1 (UART_ARB_STATS_EN)
//------------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int DATA_W      = 8,
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic              clk_sis,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_busy,
    output logic [1:0]        grant,
    output logic              busy,
    output logic              ack_err,
    output logic              err_id
`ifdef UART_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  tx_count0,
    output logic [CNT_W-1:0]  tx_count1
`endif
);

    // The acknowledge timer counts 0 .. ACK_TIMEOUT-1, so it needs
    // clog2(ACK_TIMEOUT) bits, with a minimum width of one bit.
    localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t            state;
    state_t            next_state;

    // last_ptr is the most recently granted requester. It equals the current
    // owner for as long as a frame is in flight.
    logic              last_ptr;
    logic [TMR_W-1:0]  ack_timer;

    logic              any_valid;
    logic              winner;
    logic              accept;
    logic              timeout_hit;
    logic              frame_done;

    // Round-robin choice. With a single valid requester, that requester
    // wins. With both valid, the one not served last wins. Because reset sets
    // last_ptr to 1, requester 0 takes the first tie.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            winner = ~last_ptr;
        end else begin
            winner = req1_valid;
        end
    end

    // Ready is gated by rst so that no handshake is reported while a reset
    // would discard the capture.
    assign req0_ready = rst && (state == IDLE) && !winner && req0_valid;
    assign req1_ready = rst && (state == IDLE) &&  winner && req1_valid;

    assign busy = (state != IDLE);

    // State register.
    always_ff @(posedge clk_sis) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and the single-cycle control events that drive the
    // datapath registers below.
    always_comb begin
        next_state  = state;
        accept      = 1'b0;
        timeout_hit = 1'b0;
        frame_done  = 1'b0;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    accept     = 1'b1;
                    next_state = LAUNCH;
                end
            end
            LAUNCH: begin
                next_state = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (tx_busy) begin
                    next_state = WAIT_DONE;
                end else if (ack_timer == TMR_LAST) begin
                    timeout_hit = 1'b1;
                    next_state  = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    frame_done = 1'b1;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath registers. tx_start is registered from the accept event, so
    // it is high exactly for the LAUNCH cycle. tx_data is loaded only on
    // accept, which keeps it stable for the whole frame. The timer is cleared
    // in LAUNCH and advances on every WAIT_ACK cycle without busy.
    always_ff @(posedge clk_sis) begin
        if (!rst) begin
            tx_start  <= 1'b0;
            tx_data   <= '0;
            grant     <= 2'b00;
            last_ptr  <= 1'b1;
            ack_timer <= '0;
            ack_err   <= 1'b0;
            err_id    <= 1'b0;
        end else begin
            tx_start <= accept;
            ack_err  <= timeout_hit;

            if (accept) begin
                tx_data  <= winner ? req1_data : req0_data;
                grant    <= winner ? 2'b10 : 2'b01;
                last_ptr <= winner;
            end

            if (state == LAUNCH) begin
                ack_timer <= '0;
            end else if ((state == WAIT_ACK) && !tx_busy) begin
                ack_timer <= ack_timer + TMR_W'(1);
            end

            if (timeout_hit) begin
                err_id <= last_ptr;
                grant  <= 2'b00;
            end

            if (frame_done) begin
                grant <= 2'b00;
            end
        end
    end

`ifdef UART_ARB_STATS_EN
    // Completed-frame counters, one per requester. They wrap naturally at
    // 2^CNT_W. A timed-out frame never reaches WAIT_DONE, so it is not
    // counted.
    always_ff @(posedge clk_sis) begin
        if (!rst) begin
            tx_count0 <= '0;
            tx_count1 <= '0;
        end else if (frame_done) begin
            if (last_ptr) begin
                tx_count1 <= tx_count1 + CNT_W'(1);
            end else begin
                tx_count0 <= tx_count0 + CNT_W'(1);
            end
        end
    end
`else
    // CNT_W stays in the parameter list so both builds share one interface.
    // It has no function when the counters are compiled out.
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
//------------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed self-checking bench for uart_tx_arbiter. A small transmitter model
// raises tx_busy two cycles after tx_start and holds it for ten cycles.
// Disabling the model ties tx_busy low. Counter checks exist only when
// UART_ARB_STATS_EN is defined.
//------------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    logic              clk_sis = 1'b0;
    logic              rst;
    logic              req0_valid;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              tx_start;
    logic [DATA_W-1:0] tx_data;
    logic              tx_busy = 1'b0;
    logic [1:0]        grant;
    logic              busy;
    logic              ack_err;
    logic              err_id;
`ifdef UART_ARB_STATS_EN
    logic [CNT_W-1:0]  tx_count0;
    logic [CNT_W-1:0]  tx_count1;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    logic model_en = 1'b0;
    int   model_cd = 0;
    int   model_hold = 0;

    uart_tx_arbiter #(
        .DATA_W      (DATA_W),
        .ACK_TIMEOUT (16),
        .CNT_W       (CNT_W)
    ) dut (
        .clk_sis    (clk_sis),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .grant      (grant),
        .busy       (busy),
        .ack_err    (ack_err),
        .err_id     (err_id)
`ifdef UART_ARB_STATS_EN
        ,
        .tx_count0  (tx_count0),
        .tx_count1  (tx_count1)
`endif
    );

    always #5 clk_sis = ~clk_sis;

    // Transmitter model: tx_start seen at edge k sets busy at edge k+2,
    // and busy stays high for ten cycles.
    always @(posedge clk_sis) begin
        if (!model_en) begin
            tx_busy    <= 1'b0;
            model_cd   <= 0;
            model_hold <= 0;
        end else if (tx_start) begin
            model_cd <= 1;
        end else if (model_cd == 1) begin
            model_cd   <= 0;
            tx_busy    <= 1'b1;
            model_hold <= 9;
        end else if (tx_busy) begin
            if (model_hold == 0) tx_busy <= 1'b0;
            else model_hold <= model_hold - 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [DATA_W-1:0] d0,
                                 input logic v1, input logic [DATA_W-1:0] d1);
        req0_valid = v0;
        req0_data  = d0;
        req1_valid = v1;
        req1_data  = d1;
    endtask

    // Advance one clock, then settle just past the falling edge.
    task automatic stepCycle();
        @(posedge clk_sis);
        @(negedge clk_sis);
        #1;
    endtask

    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        while (busy && n < 60) begin
            stepCycle();
            n++;
        end
        checkOutput(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [DATA_W-1:0] seq [4];
        int frames;
        int both_ready;
        int steps;
        logic data_stable;
        logic spurious;

        rst = 1'b0;
        applyStimulus(1'b1, 8'h11, 1'b1, 8'h22);
        @(negedge clk_sis);
        #1;
        repeat (3) stepCycle();

        // ---- Reset state ----
        checkOutput("rst_tx_start", 32'(tx_start), 32'd0);
        checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
        checkOutput("rst_grant", 32'(grant), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_ack_err", 32'(ack_err), 32'd0);
        checkOutput("rst_err_id", 32'(err_id), 32'd0);
        checkOutput("rst_ready0", 32'(req0_ready), 32'd0);
        checkOutput("rst_ready1", 32'(req1_ready), 32'd0);
`ifdef UART_ARB_STATS_EN
        checkOutput("rst_count0", 32'(tx_count0), 32'd0);
        checkOutput("rst_count1", 32'(tx_count1), 32'd0);
`endif

        // ---- Release: requester 0 wins the first tie ----
        model_en = 1'b1;
        rst = 1'b1;
        #1;
        checkOutput("release_ready0", 32'(req0_ready), 32'd1);
        checkOutput("release_ready1", 32'(req1_ready), 32'd0);

        // ---- Contention: both valid continuously ----
        frames = 0;
        both_ready = 0;
        for (int c = 0; c < 200 && frames < 4; c++) begin
            if (req0_ready && req1_ready) both_ready++;
            stepCycle();
            if (tx_start) begin
                seq[frames] = tx_data;
                frames++;
                if (frames == 4) applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
            end
        end
        checkOutput("cont_frames", 32'(frames), 32'd4);
        checkOutput("cont_seq0", 32'(seq[0]), 32'h11);
        checkOutput("cont_seq1", 32'(seq[1]), 32'h22);
        checkOutput("cont_seq2", 32'(seq[2]), 32'h11);
        checkOutput("cont_seq3", 32'(seq[3]), 32'h22);
        checkOutput("cont_both_ready", 32'(both_ready), 32'd0);
        waitIdle("cont_idle");

        // ---- Single byte from requester 0 ----
        applyStimulus(1'b1, 8'hA5, 1'b0, 8'h00);
        #1;
        checkOutput("single_ready0", 32'(req0_ready), 32'd1);
        stepCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        checkOutput("single_tx_start", 32'(tx_start), 32'd1);
        checkOutput("single_tx_data", 32'(tx_data), 32'hA5);
        checkOutput("single_grant", 32'(grant), 32'b01);
        stepCycle();
        checkOutput("single_start_once", 32'(tx_start), 32'd0);
        steps = 0;
        data_stable = 1'b1;
        while (busy && steps < 40) begin
            if (tx_data !== 8'hA5 || grant !== 2'b01) data_stable = 1'b0;
            stepCycle();
            steps++;
        end
        checkOutput("single_stable", 32'(data_stable), 32'd1);
        checkOutput("single_idle_steps", 32'(steps), 32'd12);
        checkOutput("single_grant_idle", 32'(grant), 32'd0);
`ifdef UART_ARB_STATS_EN
        checkOutput("single_count0", 32'(tx_count0), 32'd3);
`endif

        // ---- Timeout: transmitter never goes busy ----
        model_en = 1'b0;
        stepCycle();
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h3C);
        #1;
        checkOutput("tmo_ready1", 32'(req1_ready), 32'd1);
        stepCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        checkOutput("tmo_tx_start", 32'(tx_start), 32'd1);
        checkOutput("tmo_grant", 32'(grant), 32'b10);
        stepCycle();
        steps = 0;
        while (!ack_err && steps < 40) begin
            stepCycle();
            steps++;
        end
        checkOutput("tmo_steps", 32'(steps), 32'd16);
        checkOutput("tmo_err_id", 32'(err_id), 32'd1);
        checkOutput("tmo_grant_clr", 32'(grant), 32'd0);
        checkOutput("tmo_busy", 32'(busy), 32'd0);
        stepCycle();
        checkOutput("tmo_pulse_once", 32'(ack_err), 32'd0);
        checkOutput("tmo_err_hold", 32'(err_id), 32'd1);
`ifdef UART_ARB_STATS_EN
        checkOutput("tmo_count1", 32'(tx_count1), 32'd2);
`endif

        // ---- Next request accepted, then reset during WAIT_DONE ----
        model_en = 1'b1;
        applyStimulus(1'b1, 8'h5A, 1'b0, 8'h00);
        #1;
        checkOutput("post_tmo_ready0", 32'(req0_ready), 32'd1);
        stepCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        repeat (3) stepCycle();
        checkOutput("mid_pre_busy", 32'({busy, tx_busy, grant}), 32'b1101);
        rst = 1'b0;
        stepCycle();
        checkOutput("mid_busy", 32'(busy), 32'd0);
        checkOutput("mid_grant", 32'(grant), 32'd0);
        checkOutput("mid_tx_data", 32'(tx_data), 32'd0);
        checkOutput("mid_err_id", 32'(err_id), 32'd0);
`ifdef UART_ARB_STATS_EN
        checkOutput("mid_count0", 32'(tx_count0), 32'd0);
        checkOutput("mid_count1", 32'(tx_count1), 32'd0);
`endif
        spurious = tx_start;
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            stepCycle();
            if (tx_start || busy) spurious = 1'b1;
        end
        checkOutput("mid_no_start", 32'(spurious), 32'd0);

        // ---- 17 frames from requester 0 (counter wrap) ----
        for (int f = 0; f < 17; f++) begin
            applyStimulus(1'b1, 8'(f), 1'b0, 8'h00);
            #1;
            if (!req0_ready) checkOutput("wrap_ready0", 32'(req0_ready), 32'd1);
            stepCycle();
            applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
            waitIdle("wrap_idle");
        end
        checkOutput("wrap_last_data", 32'(tx_data), 32'd16);
`ifdef UART_ARB_STATS_EN
        checkOutput("wrap_count0", 32'(tx_count0), 32'd1);
        checkOutput("wrap_count1", 32'(tx_count1), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
